// File: rtl/pll_supervisor_pkg.sv
// Shared types and constants for the PLL supervisor.
package pll_sup_pkg;

    localparam int unsigned StateW = 3;
    localparam int unsigned LlcW   = 8;

    typedef enum logic [StateW-1:0] {
        StReset    = 3'd0,
        StWaitLock = 3'd1,
        StSettle   = 3'd2,
        StRun      = 3'd3,
        StFault    = 3'd4
    } pll_state_e;

    // Keeps retry_count at least one bit wide when no retries are allowed.
    function automatic int unsigned retry_width(int unsigned max_retries);
        return (max_retries > 0) ? $clog2(max_retries + 1) : 1;
    endfunction

endpackage

// File: rtl/pll_supervisor_if.sv
// Control/status bundle between the PLL supervisor and its surroundings.
interface pll_supervisor_if
    import pll_sup_pkg::*;
#(
    parameter int unsigned MAX_RETRIES = 3
) ();

    localparam int unsigned RetryW = retry_width(MAX_RETRIES);

    logic              pll_lock;
    logic              restart;
    logic              pll_resetb;
    logic              pll_ready;
    logic              fault;
    logic [StateW-1:0] state;
    logic [RetryW-1:0] retry_count;
    logic [LlcW-1:0]   lock_loss_count;

    modport master (
        output pll_lock, restart,
        input  pll_resetb, pll_ready, fault, state, retry_count, lock_loss_count
    );

    modport slave (
        input  pll_lock, restart,
        output pll_resetb, pll_ready, fault, state, retry_count, lock_loss_count
    );

endinterface

// File: rtl/pll_supervisor_sync_bit.sv
// Generic two-flop synchroniser for a single asynchronous status bit.
module sync_bit (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture; both stages clear to 0 on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_supervisor.sv
// Sequences PLL reset, lock acquisition, settling and loss-of-lock recovery.
module pll_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned RESET_CYCLES  = 16,
    parameter int unsigned LOCK_TIMEOUT  = 1200,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic           clk,
    input  logic           rst,
    pll_supervisor_if.slave bus
);

    localparam int unsigned Max01    = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned TimerMax = (Max01 > SETTLE_CYCLES) ? Max01 : SETTLE_CYCLES;
    localparam int unsigned TimerW   = $clog2(TimerMax + 1);
    localparam int unsigned RetryW   = retry_width(MAX_RETRIES);

    pll_state_e        state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic [LlcW-1:0]   llc_q, llc_d;
    logic              resetb_q, resetb_d;
    logic              ready_q, ready_d;
    logic              fault_q, fault_d;
    logic              lock_s;

    sync_bit u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.pll_lock),
        .q_o (lock_s)
    );

    // Next state, counters and next-cycle registered outputs.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        llc_d   = llc_q;
        if (bus.restart) begin
            state_d = StReset;
            retry_d = '0;
        end else begin
            unique case (state_q)
                StReset: begin
                    if (timer_q == TimerW'(RESET_CYCLES - 1)) state_d = StWaitLock;
                end
                StWaitLock: begin
                    // A lock arriving in the timeout cycle wins over the timeout.
                    if (lock_s) begin
                        state_d = StSettle;
                    end else if (timer_q == TimerW'(LOCK_TIMEOUT - 1)) begin
                        if (retry_q == RetryW'(MAX_RETRIES)) begin
                            state_d = StFault;
                        end else begin
                            retry_d = retry_q + RetryW'(1);
                            state_d = StReset;
                        end
                    end
                end
                StSettle: begin
                    if (!lock_s) begin
                        state_d = StWaitLock;
                    end else if (timer_q == TimerW'(SETTLE_CYCLES - 1)) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (!lock_s) begin
                        if (llc_q != {LlcW{1'b1}}) llc_d = llc_q + LlcW'(1);
                        retry_d = '0;
                        state_d = StReset;
                    end
                end
                StFault: begin
                    state_d = StFault;
                end
                default: state_d = StReset;
            endcase
        end

        // Timer counts cycles spent in the current state.
        if (bus.restart || (state_d != state_q)) begin
            timer_d = '0;
        end else if (timer_q != {TimerW{1'b1}}) begin
            timer_d = timer_q + TimerW'(1);
        end else begin
            timer_d = timer_q;
        end

        resetb_d = (state_d == StWaitLock) || (state_d == StSettle) || (state_d == StRun);
        ready_d  = (state_d == StRun);
        fault_d  = (state_d == StFault);
    end

    // State, counters and outputs all update together so outputs match the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StReset;
            timer_q  <= '0;
            retry_q  <= '0;
            llc_q    <= '0;
            resetb_q <= 1'b0;
            ready_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            retry_q  <= retry_d;
            llc_q    <= llc_d;
            resetb_q <= resetb_d;
            ready_q  <= ready_d;
            fault_q  <= fault_d;
        end
    end

    assign bus.pll_resetb      = resetb_q;
    assign bus.pll_ready       = ready_q;
    assign bus.fault           = fault_q;
    assign bus.state           = state_q;
    assign bus.retry_count     = retry_q;
    assign bus.lock_loss_count = llc_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// Directed bench for pll_supervisor: cycle-accurate vector table plus corner sequences.
module tb_pll_supervisor;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    pll_supervisor_if #(.MAX_RETRIES(2)) bus ();

    pll_supervisor #(
        .RESET_CYCLES  (4),
        .LOCK_TIMEOUT  (20),
        .SETTLE_CYCLES (8),
        .MAX_RETRIES   (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic       lock;
        logic       restart;
        logic [2:0] st;
        logic       resetb;
        logic       ready;
        logic       fault;
        logic [1:0] retry;
        logic [7:0] llc;
    } vec_t;

    vec_t vecs [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int st, input int rb, input int rd,
                             input int f, input int rt, input int llc);
        check({tag, " state"}, int'(bus.state), st);
        check({tag, " pll_resetb"}, int'(bus.pll_resetb), rb);
        check({tag, " pll_ready"}, int'(bus.pll_ready), rd);
        check({tag, " fault"}, int'(bus.fault), f);
        check({tag, " retry_count"}, int'(bus.retry_count), rt);
        check({tag, " lock_loss_count"}, int'(bus.lock_loss_count), llc);
    endtask

    // Clock until pll_ready is seen, returning the number of edges taken.
    task automatic wait_ready(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.pll_ready && n < 60);
    endtask

    // Drop lock from RUN, measure ready fall latency and resetb low time, re-raise lock.
    task automatic loss_cycle(output int fall, output int low);
        bus.pll_lock = 1'b0;
        fall = 0;
        do begin
            tick();
            fall++;
        end while (bus.pll_ready && fall < 10);
        bus.pll_lock = 1'b1;
        low = 1;
        while (!bus.pll_resetb && low < 20) begin
            tick();
            if (!bus.pll_resetb) low++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int fall;
        int low;
        int llc_exp;

        //             n   lk rs st rb rd f  rt llc
        vecs[0]  = '{3,  0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{5,  0, 0, 1, 1, 0, 0, 0, 0};
        vecs[2]  = '{2,  1, 0, 1, 1, 0, 0, 0, 0};
        vecs[3]  = '{8,  1, 0, 2, 1, 0, 0, 0, 0};
        vecs[4]  = '{3,  1, 0, 3, 1, 1, 0, 0, 0};
        vecs[5]  = '{2,  0, 0, 3, 1, 1, 0, 0, 0};
        vecs[6]  = '{4,  0, 0, 0, 0, 0, 0, 0, 1};
        vecs[7]  = '{20, 0, 0, 1, 1, 0, 0, 0, 1};
        vecs[8]  = '{4,  0, 0, 0, 0, 0, 0, 1, 1};
        vecs[9]  = '{20, 0, 0, 1, 1, 0, 0, 1, 1};
        vecs[10] = '{4,  0, 0, 0, 0, 0, 0, 2, 1};
        vecs[11] = '{20, 0, 0, 1, 1, 0, 0, 2, 1};
        vecs[12] = '{5,  0, 0, 4, 0, 0, 1, 2, 1};
        vecs[13] = '{1,  0, 1, 0, 0, 0, 0, 0, 1};
        vecs[14] = '{3,  0, 0, 0, 0, 0, 0, 0, 1};
        vecs[15] = '{1,  0, 0, 1, 1, 0, 0, 0, 1};

        bus.pll_lock = 1'b0;
        bus.restart  = 1'b0;
        #1 rst = 1'b1;
        tick();
        tick();
        check_all("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Nominal lock, run loss, timeout retries to fault, restart out of fault.
        for (int i = 0; i < 16; i++) begin
            for (int c = 0; c < vecs[i].n; c++) begin
                bus.pll_lock = vecs[i].lock;
                bus.restart  = vecs[i].restart;
                tick();
                check_all($sformatf("vec%0d.%0d", i, c), int'(vecs[i].st), int'(vecs[i].resetb),
                          int'(vecs[i].ready), int'(vecs[i].fault), int'(vecs[i].retry),
                          int'(vecs[i].llc));
            end
        end
        bus.restart = 1'b0;

        // Settle interruption: 2-cycle lock drop at SETTLE cycle 5.
        bus.pll_lock = 1'b1;
        tick(); tick(); tick();
        check("settle_entry state", int'(bus.state), 2);
        tick(); tick(); tick(); tick();
        bus.pll_lock = 1'b0;
        tick(); tick();
        bus.pll_lock = 1'b1;
        tick();
        check("settle_drop state", int'(bus.state), 1);
        check("settle_drop ready", int'(bus.pll_ready), 0);
        wait_ready(n);
        check("settle_relock latency", n + 1, 11);
        check("settle_relock retry", int'(bus.retry_count), 0);

        // Lock reaching lock_s in the timeout cycle goes to SETTLE.
        bus.restart  = 1'b1;
        bus.pll_lock = 1'b0;
        tick();
        bus.restart = 1'b0;
        check("restart_from_run state", int'(bus.state), 0);
        check("restart_from_run llc", int'(bus.lock_loss_count), 1);
        for (int i = 0; i < 21; i++) tick();
        bus.pll_lock = 1'b1;
        tick();
        tick();
        check("race_timeout_cycle state", int'(bus.state), 1);
        tick();
        check("race_lock_wins state", int'(bus.state), 2);
        check("race_lock_wins retry", int'(bus.retry_count), 0);
        wait_ready(n);
        check("race_ready reached", int'(bus.pll_ready), 1);

        // Restart coincident with a RUN lock drop is not counted as a loss.
        bus.pll_lock = 1'b0;
        tick();
        tick();
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        check("restart_vs_loss state", int'(bus.state), 0);
        check("restart_vs_loss llc", int'(bus.lock_loss_count), 1);
        check("restart_vs_loss ready", int'(bus.pll_ready), 0);
        bus.pll_lock = 1'b1;
        wait_ready(n);
        check("reacquire ready reached", int'(bus.pll_ready), 1);

        // Repeated loss in RUN saturates lock_loss_count.
        llc_exp = 1;
        for (int i = 0; i < 300; i++) begin
            loss_cycle(fall, low);
            llc_exp = (llc_exp < 255) ? llc_exp + 1 : 255;
            check($sformatf("loss%0d fall latency", i), fall, 3);
            check($sformatf("loss%0d resetb low", i), low, 4);
            check($sformatf("loss%0d llc", i), int'(bus.lock_loss_count), llc_exp);
            wait_ready(n);
            check($sformatf("loss%0d ready reached", i), int'(bus.pll_ready), 1);
        end
        check("llc saturated", int'(bus.lock_loss_count), 255);

        // Async reset asserted between edges while in SETTLE.
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        n = 0;
        while (bus.state != 3'd2 && n < 20) begin
            tick();
            n++;
        end
        check("pre_rst state", int'(bus.state), 2);
        tick();
        tick();
        #3 rst = 1'b1;
        #1;
        check_all("async_rst", 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b0;
        wait_ready(n);
        check("post_rst ready latency", n, 13);
        check("post_rst llc", int'(bus.lock_loss_count), 0);
        check("post_rst retry", int'(bus.retry_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
